// File: rtl/or1200_operand_fwd_unit.sv
// or1200_operand_fwd_unit: ID->EX operand mux, forwarding hazard detect, operand registers, stall counter.
// Optional operand parity checking is enabled by defining OR1200_OPFWD_PARITY_EN.
module or1200_operand_fwd_unit #(
  parameter int WIDTH = 32,
  parameter int NUM_OPS = 3,
  parameter int NUM_FWD = 3,
  parameter int SEL_W = 3,
  parameter logic [NUM_OPS-1:0] IMM_MASK = 3'b010,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_freeze,
  input  logic                       ex_freeze,
  input  logic [NUM_OPS*WIDTH-1:0]   rf_data,
  input  logic [WIDTH-1:0]           simm,
  input  logic [NUM_FWD*WIDTH-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_OPS*SEL_W-1:0]   sel,
  output logic [NUM_OPS*WIDTH-1:0]   muxed,
  output logic [NUM_OPS*WIDTH-1:0]   operand,
  output logic [NUM_OPS-1:0]         operand_saved,
  output logic                       op_valid,
  output logic                       fwd_stall,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic                       par_err
);
  logic [NUM_OPS-1:0] hz;
  logic [WIDTH-1:0] opr [NUM_OPS];
  logic sv [NUM_OPS];
`ifdef OR1200_OPFWD_PARITY_EN
  logic pb [NUM_OPS];
  logic [NUM_OPS-1:0] pm;
`endif
  assign fwd_stall = |hz && !id_freeze;
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    logic [SEL_W-1:0] s;
    logic [WIDTH-1:0] m;
    logic h;
    logic ld;
    assign s = sel[i*SEL_W +: SEL_W];
    always_comb begin
      m = (s == SEL_W'(1) && IMM_MASK[i]) ? simm : rf_data[i*WIDTH +: WIDTH];
      h = 1'b0;
      for (int k = 0; k < NUM_FWD; k++)
        if (s == SEL_W'(k + 2)) begin
          m = fwd_data[k*WIDTH +: WIDTH];
          h = !fwd_valid[k];
        end
    end
    assign muxed[i*WIDTH +: WIDTH] = m;
    assign hz[i] = h;
    assign ld = !ex_freeze && !fwd_stall && !sv[i];
    // a saved operand is frozen until ID releases, so it cannot be overwritten
    always_ff @(posedge clk)
      if (rst) begin
        opr[i] <= '0;
        sv[i] <= 1'b0;
      end else if (ld) begin
        opr[i] <= m;
        if (id_freeze) sv[i] <= 1'b1;
      end else if (!ex_freeze && !id_freeze) sv[i] <= 1'b0;
    assign operand[i*WIDTH +: WIDTH] = opr[i];
    assign operand_saved[i] = sv[i];
`ifdef OR1200_OPFWD_PARITY_EN
    always_ff @(posedge clk)
      if (rst) pb[i] <= 1'b0;
      else if (ld) pb[i] <= ^m;
    assign pm[i] = pb[i] ^ (^opr[i]);
`endif
  end
  always_ff @(posedge clk)
    if (rst) op_valid <= 1'b0;
    else if (!ex_freeze) op_valid <= !fwd_stall;
  always_ff @(posedge clk)
    if (rst) stall_cnt <= '0;
    else if (fwd_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
`ifdef OR1200_OPFWD_PARITY_EN
  always_ff @(posedge clk)
    if (rst) par_err <= 1'b0;
    else if (op_valid && |pm) par_err <= 1'b1;
`else
  assign par_err = 1'b0;
`endif
endmodule

// File: doc/or1200_operand_fwd_unit.md
Name: or1200_operand_fwd_unit

Overview:
- Parametrised operand-fetch and forwarding unit for the OR1200 ID→EX boundary.
- Generalises the two-operand mux to NUM_OPS operands, NUM_FWD forwarding sources, and a per-operand immediate option.
- Adds forward-validity hazard detection, an EX bubble flag and a saturating stall counter.
- Sits between the register file read ports, the forwarding network and the EX-stage ALU/LSU.

Parameters:
WIDTH, 32, operand width in bits
NUM_OPS, 3, number of operand channels
NUM_FWD, 3, number of forwarding sources (0=EX, 1=MEM, 2=WB)
SEL_W, 3, select field width per operand; must satisfy 2^SEL_W >= NUM_FWD+2
IMM_MASK, 3'b010, bit i set = operand i may select simm
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
id_freeze  in  1  ID stage frozen
ex_freeze  in  1  EX stage frozen
rf_data  in  NUM_OPS*WIDTH  register file read data, operand i at [i*WIDTH +: WIDTH]
simm  in  WIDTH  sign-extended immediate
fwd_data  in  NUM_FWD*WIDTH  forwarding values, source k at [k*WIDTH +: WIDTH]
fwd_valid  in  NUM_FWD  forwarding value k is final this cycle
sel  in  NUM_OPS*SEL_W  per-operand select
muxed  out  NUM_OPS*WIDTH  combinational muxed operands
operand  out  NUM_OPS*WIDTH  registered EX operands
operand_saved  out  NUM_OPS  per-operand saved flag
op_valid  out  1  registered operands are a real instruction (0 = bubble)
fwd_stall  out  1  forwarding hazard, combinational
stall_cnt  out  CNT_W  saturating count of fwd_stall cycles
par_err  out  1  operand parity error (optional feature only; tied 0 otherwise)

Behaviour:
- Select decode per operand i:
  - sel=0: rf_data[i].
  - sel=1: simm if IMM_MASK[i], else rf_data[i].
  - sel=2+k, k<NUM_FWD: fwd_data[k].
  - Any other value: rf_data[i].
- muxed is purely combinational, zero latency.
- fwd_stall = OR over i of (sel_i selects source k AND !fwd_valid[k]) AND !id_freeze.
- Operand register i, evaluated in priority order each posedge:
  1. rst: operand_i=0, saved_i=0.
  2. !ex_freeze && !fwd_stall && id_freeze && !saved_i: operand_i<=muxed_i, saved_i<=1.
  3. !ex_freeze && !fwd_stall && !saved_i: operand_i<=muxed_i.
  4. !ex_freeze && !id_freeze: saved_i<=0, operand_i holds.
  5. Otherwise: hold.
- While saved_i=1, operand_i is never overwritten. A value captured under id_freeze therefore survives until ID releases.
- op_valid:
  - Reset 0.
  - On !ex_freeze: op_valid<=!fwd_stall.
  - On ex_freeze: hold.
  - A stall therefore inserts exactly one bubble per stalled cycle.
- stall_cnt:
  - Reset 0.
  - Increments on every cycle with fwd_stall=1; ex_freeze does not affect counting.
  - Saturates at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - fwd_stall with ex_freeze=1: registers hold; counter still increments.
  - rst has priority over everything, including mid-stall and mid-save; all registered outputs read 0 the following cycle.
- All registered outputs are 0 after reset; muxed follows its inputs immediately.

Optional Feature:
- Macro OR1200_OPFWD_PARITY_EN.
- Defined:
  - One even-parity bit is stored per operand, computed from muxed_i at load.
  - par_err is registered. It is asserted the cycle after any operand_i whose stored parity mismatches ^operand_i while op_valid=1.
  - par_err is cleared only by rst.
- Undefined: no parity storage; par_err is constant 0.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> operand=0, saved=0, op_valid=0, stall_cnt=0, par_err=0.
- Forward select: NUM_OPS=3, sel_0=2, sel_1=1, sel_2=4, fwd_data[0]=0xA5A5A5A5, fwd_data[2]=0x0000BEEF, simm=0x12, all fwd_valid=1, no freezes -> muxed same cycle; operand next cycle={0x0000BEEF, 0x12, 0xA5A5A5A5}, op_valid=1.
- Immediate masking: sel_0=1 with IMM_MASK[0]=0, rf_data[0]=0x77 -> operand_0=0x77.
- Save under freeze: id_freeze=1, ex_freeze=0, muxed_0=0x11; next cycle muxed_0=0x22 -> operand_0=0x11, saved_0=1 and stays 0x11; id_freeze drop -> saved_0=0, then load resumes.
- Forward hazard: sel_0=3 (MEM), fwd_valid[1]=0 for 3 cycles then 1 -> fwd_stall=1 for 3 cycles, op_valid=0 for 3 cycles, operand_0 held, stall_cnt=3, then load and op_valid=1.
- Saturation: CNT_W=4, hold fwd_stall for 20 cycles -> stall_cnt stops at 15.
